// File: rtl/reg_file_scoreboarded.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_scoreboarded
// Description : Multi-port register file with a busy-bit scoreboard.
//               It has an optional write-to-read bypass and an optional
//               hardwired-zero register 0.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_scoreboarded #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int ZERO_REG    = 1,
    parameter int BYPASS      = 1,
    parameter int AW          = $clog2(NUM_REGS)   // derived, leave at default
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [READ_PORTS*AW-1:0]          readAddr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  readValue,
    output logic [READ_PORTS-1:0]             readReady,
    input  logic                              reserveEnable,
    input  logic [AW-1:0]                     reserveAddr,
    input  logic [WRITE_PORTS-1:0]            writeEnable,
    input  logic [WRITE_PORTS*AW-1:0]         writeAddr,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] writeValue,
    output logic [NUM_REGS-1:0]               busyMask
);

    localparam logic          c_ZERO_EN   = (ZERO_REG != 0);
    localparam logic          c_BYPASS_EN = (BYPASS != 0);
    localparam logic [AW-1:0] c_REG0      = '0;

    logic [DATA_WIDTH-1:0]  r_body [NUM_REGS];
    logic [NUM_REGS-1:0]    r_busy;
    logic [NUM_REGS-1:0]    w_busy_next;
    logic [WRITE_PORTS-1:0] w_wr_valid;
    logic                   w_res_valid;

    assign busyMask = r_busy;

    // Qualify strobes: with a hardwired r0, anything aimed at r0 is dropped
    always_comb begin
        w_wr_valid  = '0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            w_wr_valid[w] = writeEnable[w] &&
                            !(c_ZERO_EN && (writeAddr[w*AW +: AW] == c_REG0));
        end
        w_res_valid = reserveEnable && !(c_ZERO_EN && (reserveAddr == c_REG0));
    end

    // Register storage; later (higher-index) ports override earlier ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_body[i] <= '0;
            end
        end else begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (w_wr_valid[w]) begin
                    r_body[writeAddr[w*AW +: AW]] <= writeValue[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next busy bits: writeback clears, a reservation sets and takes priority
    always_comb begin
        w_busy_next = r_busy;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (w_wr_valid[w]) begin
                w_busy_next[writeAddr[w*AW +: AW]] = 1'b0;
            end
        end
        if (w_res_valid) begin
            w_busy_next[reserveAddr] = 1'b1;
        end
        if (c_ZERO_EN) begin
            w_busy_next[0] = 1'b0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    generate
        for (genvar r = 0; r < READ_PORTS; r++) begin : g_read
            logic [AW-1:0]         w_addr;
            logic                  w_hit;
            logic [DATA_WIDTH-1:0] w_fwd;
            logic [DATA_WIDTH-1:0] w_val;
            logic                  w_rdy;

            assign w_addr = readAddr[r*AW +: AW];

            // Forwarding search: the highest-index matching write port wins
            always_comb begin
                w_hit = 1'b0;
                w_fwd = '0;
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    if (c_BYPASS_EN && w_wr_valid[w] && (writeAddr[w*AW +: AW] == w_addr)) begin
                        w_hit = 1'b1;
                        w_fwd = writeValue[w*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            // Read mux: reset and r0 force zero/ready, then bypass, then storage
            always_comb begin
                w_val = r_body[w_addr];
                w_rdy = !r_busy[w_addr];
                if (rst || (c_ZERO_EN && (w_addr == c_REG0))) begin
                    w_val = '0;
                    w_rdy = 1'b1;
                end else if (w_hit) begin
                    w_val = w_fwd;
                    w_rdy = 1'b1;
                end
            end

            assign readValue[r*DATA_WIDTH +: DATA_WIDTH] = w_val;
            assign readReady[r]                          = w_rdy;
        end
    endgenerate

endmodule
`default_nettype wire
